// File: rtl/axil_sram_responder_if.sv
// AXI-Lite bundle between cache/LSU initiators and the SRAM responder.
// Ports: AR/R read channels, AW/W/B write channels; master and slave modports.
interface axil_sram_responder_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_sram_responder.sv
// AXI-Lite slave backing a word-addressed SRAM with a per-access delay.
// Ports: clk, rst (sync, active-high), s (axil_sram_responder_if.slave).
// One transaction in flight; a read wins over a simultaneous write.
// Define AXIL_SRAM_RAND_DELAY_EN to draw the delay from an 8-bit LFSR
// instead of FIXED_DELAY.
module axil_sram_responder #(
    parameter int unsigned ADDR_DIG    = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned FIXED_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    axil_sram_responder_if.slave  s
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] R_WAIT = 3'd1;
    localparam logic [2:0] R_RESP = 3'd2;
    localparam logic [2:0] W_WAIT = 3'd3;
    localparam logic [2:0] B_RESP = 3'd4;

    localparam int unsigned DEPTH = 1 << ADDR_DIG;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    logic [31:0] mem [DEPTH];

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [3:0]  dly;

`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8+x^6+x^5+x^4+1, free-running so the delay varies per request
    always_comb begin
        lfsr_d = {lfsr_q[6:0],
                  lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= lfsr_d;
    end

    assign dly = {1'b0, lfsr_q[2:0]};
`else
    localparam logic [3:0] FIX_D = 4'(FIXED_DELAY % 16);

    assign dly = FIX_D;
`endif

    // In IDLE the decode looks at the live bus address so a zero delay
    // can respond straight from the handshake; otherwise the latched one.
    logic [31:0]         dec_addr;
    logic [32:0]         off;
    logic                in_rng;
    logic [ADDR_DIG-1:0] idx;
    logic [31:0]         wr_data;
    logic [3:0]          wr_strb;
    logic [31:0]         rd_word;
    logic                mem_we;
    logic                aw_go;
    logic                unused_low;

    always_comb begin
        dec_addr = addr_q;
        wr_data  = wdata_q;
        wr_strb  = wstrb_q;
        if (state_q == IDLE) begin
            dec_addr = s.arvalid ? s.araddr : s.awaddr;
            wr_data  = s.wdata;
            wr_strb  = s.wstrb;
        end
    end

    assign off        = {1'b0, dec_addr} - {1'b0, BASE_ADDR};
    assign in_rng     = !off[32] && (off < SPAN);
    assign idx        = off[ADDR_DIG+1:2];
    assign unused_low = ^off[1:0];
    assign rd_word    = in_rng ? mem[idx] : 32'h0;

    assign aw_go = (state_q == IDLE) && !s.arvalid
                && s.awvalid && s.wvalid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        bresp_d = bresp_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s.arvalid) begin
                    addr_d = s.araddr;
                    cnt_d  = dly;
                    if (dly == 4'd0) begin
                        rdata_d = rd_word;
                        rresp_d = in_rng ? 2'b00 : 2'b10;
                        state_d = R_RESP;
                    end else begin
                        state_d = R_WAIT;
                    end
                end else if (aw_go) begin
                    addr_d  = s.awaddr;
                    wdata_d = s.wdata;
                    wstrb_d = s.wstrb;
                    cnt_d   = dly;
                    if (dly == 4'd0) begin
                        mem_we  = in_rng;
                        bresp_d = in_rng ? 2'b00 : 2'b10;
                        state_d = B_RESP;
                    end else begin
                        state_d = W_WAIT;
                    end
                end
            end
            R_WAIT: begin
                // the decremented count reaching 0 ends the wait
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    rdata_d = rd_word;
                    rresp_d = in_rng ? 2'b00 : 2'b10;
                    state_d = R_RESP;
                end
            end
            W_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    mem_we  = in_rng;
                    bresp_d = in_rng ? 2'b00 : 2'b10;
                    state_d = B_RESP;
                end
            end
            R_RESP: begin
                if (s.rready) state_d = IDLE;
            end
            B_RESP: begin
                if (s.bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
            rresp_q <= 2'b00;
            bresp_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            bresp_q <= bresp_d;
        end
    end

    // SRAM array is never reset; a reset on the commit edge aborts it
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign s.arready = (state_q == IDLE);
    assign s.awready = aw_go;
    assign s.wready  = aw_go;
    assign s.rvalid  = (state_q == R_RESP);
    assign s.bvalid  = (state_q == B_RESP);
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
    assign s.bresp   = bresp_q;

endmodule

// File: tb/tb_axil_sram_responder.sv
// Directed bench for axil_sram_responder (default build, delay 2).
// Drives and samples on the falling clock edge.
module tb_axil_sram_responder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    axil_sram_responder_if bus();

    axil_sram_responder dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] st, output int lat,
                            output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = st;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        n = 0;
        while (!bus.awready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL aw_accept_timeout: awready never 1 for %h", a);
        end
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        lat = 1;
        while (!bus.bvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        resp = bus.bresp;
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int lat,
                           output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.arready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL ar_accept_timeout: arready never 1 for %h", a);
        end
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        lat = 1;
        while (!bus.rvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        d    = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_rvalid: got %b want 0", bus.rvalid);
        end
        n_checks++;
        if (bus.bvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_bvalid: got %b want 0", bus.bvalid);
        end
        n_checks++;
        if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.rdata);
        end
        n_checks++;
        if (bus.rresp !== 2'b00 || bus.bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_resp: got r=%b b=%b want 00", bus.rresp, bus.bresp);
        end
        n_checks++;
        if (bus.arready !== 1'b1) begin
            n_fail++; $display("FAIL rst_arready: got %b want 1", bus.arready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] d;
        do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, lat, resp);
        n_checks++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL wr_latency: got %0d want 3", lat);
        end
        n_checks++;
        if (resp !== 2'b00) begin
            n_fail++; $display("FAIL wr_bresp: got %b want 00", resp);
        end
        do_read(32'h8000_0010, lat, d, resp);
        n_checks++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL rd_latency: got %0d want 3", lat);
        end
        n_checks++;
        if (d !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd_data: got %h want deadbeef", d);
        end
        n_checks++;
        if (resp !== 2'b00) begin
            n_fail++; $display("FAIL rd_rresp: got %b want 00", resp);
        end
        do_read(32'h8000_0013, lat, d, resp);
        n_checks++;
        if (d !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd_unaligned: got %h want deadbeef", d);
        end
    endtask

    task automatic test_strobe;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] d;
        do_write(32'h8000_0020, 32'h11223344, 4'hF, lat, resp);
        do_write(32'h8000_0020, 32'hAABBCCDD, 4'b0101, lat, resp);
        do_read(32'h8000_0020, lat, d, resp);
        n_checks++;
        if (d !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL strobe_merge: got %h want 11bb33dd", d);
        end
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'h0, lat, resp);
        n_checks++;
        if (resp !== 2'b00) begin
            n_fail++; $display("FAIL strobe_zero_bresp: got %b want 00", resp);
        end
        do_read(32'h8000_0020, lat, d, resp);
        n_checks++;
        if (d !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL strobe_zero_data: got %h want 11bb33dd", d);
        end
    endtask

    task automatic test_collision;
        int          n;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] d;
        @(negedge clk);
        bus.araddr  = 32'h8000_0010;
        bus.arvalid = 1'b1;
        bus.awaddr  = 32'h8000_0030;
        bus.wdata   = 32'hCAFEF00D;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        n_checks++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_first: got ar=%b aw=%b w=%b want 1 0 0",
                     bus.arready, bus.awready, bus.wready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        n = 1;
        while (!bus.rvalid && n < 40) begin
            #1;
            n_checks++;
            if (bus.awready !== 1'b0) begin
                n_fail++; $display("FAIL coll_wait_awready: got %b want 0", bus.awready);
            end
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== 3 || bus.rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL coll_read: got lat %0d data %h want 3 deadbeef", n, bus.rdata);
        end
        bus.rready = 1'b1;
        #1;
        n_checks++;
        if (bus.awready !== 1'b0) begin
            n_fail++; $display("FAIL coll_rresp_awready: got %b want 0", bus.awready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        #1;
        n_checks++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_after: got aw=%b w=%b want 1 1", bus.awready, bus.wready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 1;
        while (!bus.bvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== 3 || bus.bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL coll_write: got lat %0d bresp %b want 3 00", n, bus.bresp);
        end
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        do_read(32'h8000_0030, lat, d, resp);
        n_checks++;
        if (d !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL coll_readback: got %h want cafef00d", d);
        end
    endtask

    task automatic test_range;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] d;
        do_write(32'h8000_0000, 32'h01020304, 4'hF, lat, resp);
        do_read(32'h8000_1000, lat, d, resp);
        n_checks++;
        if (resp !== 2'b10 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read: got resp %b data %h want 10 0", resp, d);
        end
        do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, lat, resp);
        n_checks++;
        if (resp !== 2'b10) begin
            n_fail++; $display("FAIL oor_write: got %b want 10", resp);
        end
        do_read(32'h8000_0000, lat, d, resp);
        n_checks++;
        if (d !== 32'h01020304) begin
            n_fail++; $display("FAIL oor_no_alias: got %h want 01020304", d);
        end
        do_write(32'h8000_0FFC, 32'h600DF00D, 4'hF, lat, resp);
        n_checks++;
        if (resp !== 2'b00) begin
            n_fail++; $display("FAIL last_write: got %b want 00", resp);
        end
        do_read(32'h8000_0FFC, lat, d, resp);
        n_checks++;
        if (resp !== 2'b00 || d !== 32'h600DF00D) begin
            n_fail++;
            $display("FAIL last_read: got resp %b data %h want 00 600df00d", resp, d);
        end
        do_read(32'h7FFF_FFFC, lat, d, resp);
        n_checks++;
        if (resp !== 2'b10 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL below_base: got resp %b data %h want 10 0", resp, d);
        end
    endtask

    task automatic test_hold;
        int          n;
        int          lat;
        logic [1:0]  resp;
        do_write(32'h8000_0050, 32'h0BADCAFE, 4'hF, lat, resp);
        @(negedge clk);
        bus.araddr  = 32'h8000_0050;
        bus.arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.araddr  = 32'h8000_0000;
        n = 1;
        while (!bus.rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0BADCAFE ||
                bus.rresp !== 2'b00 || bus.arready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: got v=%b d=%h r=%b ar=%b want 1 0badcafe 00 0",
                         i, bus.rvalid, bus.rdata, bus.rresp, bus.arready);
            end
            @(negedge clk);
        end
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        n_checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got v=%b ar=%b want 0 1", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_reset_mid;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] d;
        do_write(32'h8000_0040, 32'h0, 4'hF, lat, resp);
        @(negedge clk);
        bus.awaddr  = 32'h8000_0040;
        bus.wdata   = 32'h5A5A5A5A;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.bvalid !== 1'b0 || bus.arready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_idle: got bvalid %b arready %b want 0 1",
                     bus.bvalid, bus.arready);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.bvalid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_bvalid: got %b want 0", bus.bvalid);
        end
        do_read(32'h8000_0040, lat, d, resp);
        n_checks++;
        if (d !== 32'h0 || resp !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_data: got %h resp %b want 0 00", d, resp);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.araddr  = 32'h0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awaddr  = 32'h0;
        bus.awvalid = 1'b0;
        bus.wdata   = 32'h0;
        bus.wstrb   = 4'h0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        test_reset;
        test_write_read;
        test_strobe;
        test_collision;
        test_range;
        test_hold;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_sram_responder.md
Name: axil_sram_responder

Overview:
AXI-Lite slave (memory-side responder) that terminates the read requests the instruction cache and LSU issue on a miss, and the stores the LSU issues.
- Backs a word-addressed on-chip SRAM array and adds a configurable access delay, so the initiators' wait states are exercised.
- Handles one transaction outstanding at a time; reads take priority over writes.

Parameters:
ADDR_DIG, 10, log2 of the memory depth in 32-bit words (1024 words).
BASE_ADDR, 32'h8000_0000, byte address of word 0.
FIXED_DELAY, 2, wait cycles between the request handshake and the response valid (0..15).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
araddr  in  32  read byte address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response: 00 OKAY, 10 SLVERR
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  32  write byte address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte enables
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response: 00 OKAY, 10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset: rst sampled on the clk edge. State goes to IDLE, delay counter to 0, latches cleared.
  - rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00.
  - SRAM contents are not reset.
- States: IDLE, R_WAIT, R_RESP, W_WAIT, B_RESP.
- arready = (state==IDLE). Combinational.
- awready = wready = (state==IDLE && !arvalid && awvalid && wvalid).
  - AW and W are accepted together only; one without the other is never accepted.
- Simultaneous arvalid and awvalid&&wvalid in IDLE: the read wins. The write stays pending and is accepted the cycle after the read's rvalid&&rready completes.
- Read handshake (IDLE, arvalid):
  - Latch araddr; load counter with the delay D; go to R_WAIT.
  - R_WAIT decrements the counter; at 0 it samples SRAM into rdata, sets rresp, and moves to R_RESP.
  - Net latency: handshake in cycle T, rvalid high in cycle T+1+D.
- R_RESP: rvalid=1. rdata and rresp are held stable until rready. On rvalid&&rready go to IDLE, rvalid=0 next cycle.
- Write handshake (IDLE): latch awaddr, wdata, wstrb; load counter; go to W_WAIT.
  - At counter 0, commit to SRAM (byte lanes with wstrb[i]=1 only), set bresp, go to B_RESP.
  - bvalid high in cycle T+1+D.
- B_RESP: bvalid=1, held until bready, then IDLE.
- Address decode:
  - Word index = (addr - BASE_ADDR) >> 2, low ADDR_DIG bits. addr[1:0] is ignored (word access).
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_DIG.
  - Out of range read: rresp=10, rdata=32'h0.
  - Out of range write: bresp=10, no SRAM change.
  - Last word, BASE_ADDR+4*(2^ADDR_DIG-1), is in range; the next address is out of range.
- wstrb=0 in range: no SRAM change, bresp=00.
- Reset mid-operation (R_WAIT, W_WAIT, R_RESP, B_RESP): the response is discarded and the state returns to IDLE. A write still in W_WAIT is aborted and not committed.
- Counter width is 4 bits, and FIXED_DELAY above 15 is truncated mod 16.

Optional Feature:
Macro AXIL_SRAM_RAND_DELAY_EN.
- Defined:
  - D = lfsr[2:0] (0..7) sampled at each request handshake.
  - lfsr is 8 bits, Fibonacci, taps x^8+x^6+x^5+x^4+1, reset to 8'hA5, and advances every cycle including IDLE.
- Undefined: D = FIXED_DELAY and no LFSR is built.
- Handshake rules and responses are identical in both builds.

Test Plan:
- Write 32'hDEADBEEF to 32'h8000_0010 with wstrb 4'hF, then read it back with default delay: bvalid in cycle T+3, bresp=00; read rvalid in cycle T+3, rdata=32'hDEADBEEF, rresp=00.
- Write 32'h11223344 with wstrb 4'hF, then 32'hAABBCCDD with wstrb 4'b0101 to the same word, then read: rdata=32'h11BB33DD.
- In IDLE, assert arvalid on 32'h8000_0010 and awvalid+wvalid together in the same cycle: read accepted first (awready=0 that cycle); write accepted the cycle after the read completes.
- Read 32'h8000_1000 (first address past the 1024-word window) -> rresp=10, rdata=0. Write there -> bresp=10. Reading 32'h8000_0FFC -> rresp=00.
- Hold rready=0 for 5 cycles after rvalid: rvalid stays 1 and rdata/rresp stay unchanged; arready stays 0.
- Assert rst during W_WAIT of a write of 32'h5A5A5A5A over a word holding 32'h0: next cycle state is IDLE, bvalid=0; a read of that word returns 32'h0.
